// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority vote per bit, parity/framing/break
// detection, and a show-ahead FIFO of received words drained over valid/ready.
module uart_rx_os #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          os_tick,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_frame_err,
  output logic                          m_parity_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          break_det
);

  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned WW = DATA_BITS + 2;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_S0   = CW'(M - 1);
  localparam logic [CW-1:0] C_S1   = CW'(M);
  localparam logic [CW-1:0] C_VOTE = CW'(M + 1);
  localparam logic [CW-1:0] C_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] C_BINC = BW'(1);
  localparam logic [AW-1:0] C_PINC = AW'(1);
  localparam logic [AW:0]   C_LINC = (AW+1)'(1);
  localparam logic [AW:0]   C_FULL = (AW+1)'(FIFO_DEPTH);
  localparam bit            TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRK
  } state_t;

  // Input synchroniser
  logic r_sync1, r_sync2;
  logic w_rx_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_i = r_sync2;

  // Receiver state
  state_t                 r_state, w_state_n;
  logic [CW-1:0]          r_cnt, w_cnt_n;
  logic [BW-1:0]          r_bit_idx, w_bit_idx_n;
  logic [DATA_BITS-1:0]   r_shift, w_shift_n;
  logic                   r_pbit, w_pbit_n;
  logic                   r_perr, w_perr_n;
  logic                   r_ferr, w_ferr_n;
  logic                   r_stop_idx, w_stop_idx_n;
  logic                   r_s0, r_s1;

  logic                   w_vote;
  logic [CW-1:0]          w_cnt_inc;
  logic                   w_at_vote;
  logic                   w_bit_end;
  logic                   w_stop_final;
  logic                   w_par_x;
  logic                   w_push;
  logic                   w_push_ferr;
  logic                   w_push_brk;

  assign w_vote       = (r_s0 & r_s1) | (r_s0 & w_rx_i) | (r_s1 & w_rx_i);
  assign w_bit_end    = (r_cnt == C_END);
  assign w_at_vote    = (r_cnt == C_VOTE);
  assign w_cnt_inc    = w_bit_end ? '0 : r_cnt + C_ONE;
  assign w_stop_final = !TWO_STOP || r_stop_idx;
  assign w_par_x      = (^r_shift) ^ w_vote;

  // The first two votes are latched; the third is the live line value at cnt=M+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (os_tick) begin
      if (r_cnt == C_S0) r_s0 <= w_rx_i;
      if (r_cnt == C_S1) r_s1 <= w_rx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_pbit     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_bit_idx  <= w_bit_idx_n;
      r_shift    <= w_shift_n;
      r_pbit     <= w_pbit_n;
      r_perr     <= w_perr_n;
      r_ferr     <= w_ferr_n;
      r_stop_idx <= w_stop_idx_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_bit_idx_n  = r_bit_idx;
    w_shift_n    = r_shift;
    w_pbit_n     = r_pbit;
    w_perr_n     = r_perr;
    w_ferr_n     = r_ferr;
    w_stop_idx_n = r_stop_idx;
    w_push       = 1'b0;
    w_push_ferr  = 1'b0;
    w_push_brk   = 1'b0;

    if (os_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_i) begin
            w_state_n    = S_START;
            w_cnt_n      = C_ONE;
            w_bit_idx_n  = '0;
            w_pbit_n     = 1'b0;
            w_perr_n     = 1'b0;
            w_ferr_n     = 1'b0;
            w_stop_idx_n = 1'b0;
          end
        end

        S_START: begin
          w_cnt_n = w_cnt_inc;
          if (w_at_vote && w_vote) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
          end else if (w_bit_end) begin
            w_state_n   = S_DATA;
            w_bit_idx_n = '0;
          end
        end

        S_DATA: begin
          w_cnt_n = w_cnt_inc;
          if (w_at_vote) w_shift_n = {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_bit_end) begin
            if (r_bit_idx == C_LAST) w_state_n = (PARITY != 0) ? S_PAR : S_STOP;
            else                     w_bit_idx_n = r_bit_idx + C_BINC;
          end
        end

        S_PAR: begin
          w_cnt_n = w_cnt_inc;
          if (w_at_vote) begin
            w_pbit_n = w_vote;
            w_perr_n = (PARITY == 2) ? w_par_x : ~w_par_x;
          end
          if (w_bit_end) w_state_n = S_STOP;
        end

        S_STOP: begin
          w_cnt_n = w_cnt_inc;
          if (w_at_vote) begin
            if (w_stop_final) begin
              // Final stop ends at the vote so the next start edge is not missed.
              w_push      = 1'b1;
              w_push_ferr = r_ferr | ~w_vote;
              w_push_brk  = (r_shift == '0) && !r_pbit && !w_vote;
              w_state_n   = w_push_brk ? S_BRK : S_IDLE;
              w_cnt_n     = '0;
            end else begin
              w_ferr_n = ~w_vote;
            end
          end else if (w_bit_end) begin
            w_stop_idx_n = 1'b1;
          end
        end

        S_BRK: begin
          w_cnt_n = '0;
          if (w_rx_i) w_state_n = S_IDLE;
        end

        default: begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  // Show-ahead word FIFO: {parity_err, frame_err, data}
  logic [WW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_level;
  logic          r_overrun, r_break;
  logic          w_pop;
  logic          w_wr_en;
  logic [WW-1:0] w_head;

  assign m_valid = (r_level != '0);
  assign w_pop   = m_valid && m_ready;
  assign w_wr_en = w_push && ((r_level != C_FULL) || w_pop);
  assign w_head  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= {r_perr, w_push_ferr, r_shift};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      r_break   <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + C_PINC;
      if (w_pop)   r_rd <= r_rd + C_PINC;
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + C_LINC;
        2'b01:   r_level <= r_level - C_LINC;
        default: r_level <= r_level;
      endcase
      r_overrun <= w_push && !w_wr_en;
      r_break   <= w_push_brk;
    end
  end

  assign m_data       = m_valid ? w_head[DATA_BITS-1:0] : '0;
  assign m_frame_err  = m_valid & w_head[DATA_BITS];
  assign m_parity_err = m_valid & w_head[DATA_BITS+1];
  assign level        = r_level;
  assign overrun      = r_overrun;
  assign break_det    = r_break;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three instances (8N1, 8E1, 8N2) driven with
// directed frames; a negedge monitor pops expected words as each DUT presents them.
module tb_uart_rx_os;

  logic clk, rst, os_tick;
  logic rx0, rx1, rx2;
  logic ready0, ready1, ready2;
  logic [7:0] data0, data1, data2;
  logic fe0, fe1, fe2, pe0, pe1, pe2, v0, v1, v2;
  logic [2:0] lvl0, lvl1, lvl2;
  logic ovr0, ovr1, ovr2, brk0, brk1, brk2;

  int n_chk = 0;
  int n_pass = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .os_tick(os_tick), .m_data(data0), .m_frame_err(fe0),
    .m_parity_err(pe0), .m_valid(v0), .m_ready(ready0), .level(lvl0), .overrun(ovr0), .break_det(brk0));

  uart_rx_os #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .os_tick(os_tick), .m_data(data1), .m_frame_err(fe1),
    .m_parity_err(pe1), .m_valid(v1), .m_ready(ready1), .level(lvl1), .overrun(ovr1), .break_det(brk1));

  uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .os_tick(os_tick), .m_data(data2), .m_frame_err(fe2),
    .m_parity_err(pe2), .m_valid(v2), .m_ready(ready2), .level(lvl2), .overrun(ovr2), .break_det(brk2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // os_tick: one clk in four
  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) begin
        @(posedge clk);
        #1 os_tick = 1'b0;
      end
      @(posedge clk);
      #1 os_tick = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic push_exp(input int k, input logic pe, input logic fe, input logic [7:0] d);
    case (k)
      0:       q0.push_back({pe, fe, d});
      1:       q1.push_back({pe, fe, d});
      default: q2.push_back({pe, fe, d});
    endcase
  endtask

  task automatic take(input int k, input logic [9:0] got);
    logic [9:0] e;
    int sz;
    e = '0;
    case (k)
      0:       begin sz = q0.size(); if (sz != 0) e = q0.pop_front(); end
      1:       begin sz = q1.size(); if (sz != 0) e = q1.pop_front(); end
      default: begin sz = q2.size(); if (sz != 0) e = q2.pop_front(); end
    endcase
    if (sz == 0) begin
      n_chk++;
      $display("FAIL unexpected_word_dut%0d: got %0h expected none", k, got);
    end else begin
      chk($sformatf("word_dut%0d", k), {22'd0, got}, {22'd0, e});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (v0 && ready0) take(0, {pe0, fe0, data0});
      if (v1 && ready1) take(1, {pe1, fe1, data1});
      if (v2 && ready2) take(2, {pe2, fe2, data2});
      ovr_cnt += int'(ovr0);
      brk_cnt += int'(brk0);
    end
  end

  // Returns at the clk edge on which the DUT sees the n-th os_tick from now.
  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
  endtask

  task automatic sync_tick();
    tick_wait(1);
    #1;
  endtask

  task automatic set_rx(input int k, input logic v);
    case (k)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Bits LSB first, 16 ticks each; bit g gets a 1-tick inversion at its midpoint.
  task automatic send_bits(input int k, input logic [15:0] bits, input int n, input int g);
    for (int i = 0; i < n; i++) begin
      set_rx(k, bits[i]);
      if (i == g) begin
        tick_wait(8);
        #1 set_rx(k, ~bits[i]);
        tick_wait(1);
        #1 set_rx(k, bits[i]);
        tick_wait(7);
      end else begin
        tick_wait(16);
      end
      #1;
    end
  endtask

  task automatic idle(input int k, input int n);
    set_rx(k, 1'b1);
    tick_wait(n);
    #1;
  endtask

  initial begin
    int pending;
    rst = 1'b1;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_level", {29'd0, lvl0}, 32'd0);
    chk("rst_data", {24'd0, data0}, 32'd0);
    chk("rst_flags", {28'd0, fe0, pe0, ovr0, brk0}, 32'd0);
    sync_tick();

    // Clean 8N1 back-to-back
    push_exp(0, 1'b0, 1'b0, 8'hA5);
    push_exp(0, 1'b0, 1'b0, 8'h3C);
    send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1);
    send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1);
    idle(0, 24);

    // Even parity: 0x03 with p=1 -> error, 0x07 with p=1 -> ok
    push_exp(1, 1'b1, 1'b0, 8'h03);
    push_exp(1, 1'b0, 1'b0, 8'h07);
    send_bits(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, -1);
    send_bits(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, -1);
    idle(1, 24);

    // Low stop bit, then mid-sample glitch on data bit 3, then short low pulse
    push_exp(0, 1'b0, 1'b1, 8'h55);
    send_bits(0, 16'({1'b0, 8'h55, 1'b0}), 10, -1);
    idle(0, 32);
    push_exp(0, 1'b0, 1'b0, 8'h55);
    send_bits(0, 16'({1'b1, 8'h55, 1'b0}), 10, 4);
    idle(0, 24);
    rx0 = 1'b0;
    tick_wait(4);
    #1;
    idle(0, 40);
    chk("glitch_no_word_valid", {31'd0, v0}, 32'd0);
    chk("glitch_no_word_level", {29'd0, lvl0}, 32'd0);

    // Overrun: five words into four slots with the consumer stalled
    ready0 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) push_exp(0, 1'b0, 1'b0, 8'(i));
      send_bits(0, 16'({1'b1, 8'(i), 1'b0}), 10, -1);
    end
    idle(0, 24);
    chk("ovr_level_full", {29'd0, lvl0}, 32'd4);
    chk("ovr_pulse_count", ovr_cnt, 32'd1);

    // Push coinciding with a single-cycle pop while full
    push_exp(0, 1'b0, 1'b0, 8'h0A);
    fork
      send_bits(0, 16'({1'b1, 8'h0A, 1'b0}), 10, -1);
      begin
        tick_wait(153);
        repeat (3) @(posedge clk);
        #1 ready0 = 1'b1;
        @(posedge clk);
        #1 ready0 = 1'b0;
      end
    join
    idle(0, 4);
    chk("pushpop_level", {29'd0, lvl0}, 32'd4);
    chk("pushpop_no_overrun", ovr_cnt, 32'd1);
    ready0 = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("drain_level", {29'd0, lvl0}, 32'd0);
    sync_tick();

    // Break for 20 bit times, then a normal frame
    push_exp(0, 1'b0, 1'b1, 8'h00);
    rx0 = 1'b0;
    tick_wait(320);
    #1;
    idle(0, 40);
    chk("break_pulse_count", brk_cnt, 32'd1);
    push_exp(0, 1'b0, 1'b0, 8'h81);
    send_bits(0, 16'({1'b1, 8'h81, 1'b0}), 10, -1);
    idle(0, 24);
    chk("break_single_after", brk_cnt, 32'd1);

    // Reset during data bit 4
    send_bits(0, 16'h001E, 5, -1);
    tick_wait(8);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_valid", {31'd0, v0}, 32'd0);
    chk("midrst_level", {29'd0, lvl0}, 32'd0);
    sync_tick();
    idle(0, 40);
    chk("midrst_no_word", {29'd0, lvl0}, 32'd0);
    push_exp(0, 1'b0, 1'b0, 8'h5A);
    send_bits(0, 16'({1'b1, 8'h5A, 1'b0}), 10, -1);
    idle(0, 24);

    // Two stop bits: clean, then second stop low
    push_exp(2, 1'b0, 1'b0, 8'h5A);
    send_bits(2, 16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, -1);
    push_exp(2, 1'b0, 1'b1, 8'h5A);
    send_bits(2, 16'({1'b0, 1'b1, 8'h5A, 1'b0}), 11, -1);
    idle(2, 40);

    pending = q0.size() + q1.size() + q2.size();
    for (int i = 0; i < 2000 && pending != 0; i++) begin
      @(posedge clk);
      pending = q0.size() + q1.size() + q2.size();
    end
    #1;
    chk("queues_drained", pending, 32'd0);
    chk("final_valids", {29'd0, v0, v1, v2}, 32'd0);
    chk("final_overrun_count", ovr_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
